// File: rtl/cpu_ifetch.sv
// cpu_ifetch: in-order instruction fetch with credit-based request throttling, a small
// response FIFO toward decode, and discard of responses to requests issued before a jump.
module cpu_ifetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hffff0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        p3_jump,
  input  logic [31:0] p1_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rerror,
  output logic [31:0] p2_instr,
  output logic        p2_instr_valid,
  output logic        p2_fetch_fault,
  output logic        p2_pipeline_bubble
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned UW = CW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RESET_PC[1:0] != 2'b00))
  begin : g_param_check
    $error("cpu_ifetch: DEPTH must be a power of 2 >= 2 and RESET_PC word aligned");
  end

  logic [CW-1:0] r_out, r_kill, r_count;
  logic [CW-1:0] w_out_d, w_kill_d, w_count_d, w_kill_sum;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [32:0]   r_mem [DEPTH];
  logic [32:0]   w_head;
  logic [UW-1:0] w_used;
  logic          w_empty, w_pop, w_issue, w_drop, w_push;

  always_comb begin
    w_empty        = (r_count == '0);
    w_head         = r_mem[r_rptr];
    p2_instr_valid = !w_empty && !p3_jump;
    p2_instr       = w_empty ? 32'h0 : w_head[31:0];
    p2_fetch_fault = !w_empty && w_head[32];
    w_pop          = p2_instr_valid && !stall;
    // A jump abandons the FIFO and live requests, so only stale requests still hold slots.
    if (p3_jump) begin
      w_used = UW'(r_kill);
    end else begin
      w_used = UW'(r_out) + UW'(r_kill) + UW'(r_count) - UW'(w_pop);
    end
    imem_req           = reset_n && !stall && (w_used < UW'(DEPTH));
    imem_addr          = p1_pc;
    w_issue            = imem_req && imem_ready;
    p2_pipeline_bubble = !w_issue;
    w_drop             = imem_rvalid && (r_kill != '0);
    w_push             = imem_rvalid && !w_drop && !p3_jump && (r_out != '0);
  end

  always_comb begin
    w_kill_sum = r_kill + r_out;
    w_kill_d   = r_kill;
    w_out_d    = r_out;
    w_count_d  = r_count;
    if (p3_jump) begin
      // Any response this cycle belongs to a pre-jump request and is retired here.
      w_kill_d  = (imem_rvalid && (w_kill_sum != '0)) ? w_kill_sum - CW'(1) : w_kill_sum;
      w_out_d   = w_issue ? CW'(1) : '0;
      w_count_d = '0;
    end else begin
      w_kill_d  = r_kill - CW'(w_drop);
      w_out_d   = r_out + CW'(w_issue) - CW'(w_push);
      w_count_d = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= '0;
      r_kill  <= '0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_out   <= w_out_d;
      r_kill  <= w_kill_d;
      r_count <= w_count_d;
      if (p3_jump) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        r_wptr <= r_wptr + PW'(w_push);
        r_rptr <= r_rptr + PW'(w_pop);
      end
      if (w_push) begin
        r_mem[r_wptr] <= {imem_rerror, imem_rdata};
      end
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// tb_cpu_ifetch: directed and random fetch traffic against a latency-programmable bus model,
// with an in-order scoreboard of expected words checked as decode consumes them.
module tb_cpu_ifetch;
  localparam int unsigned DEPTH = 4;

  logic        clock       = 1'b0;
  logic        reset_n     = 1'b1;
  logic        stall       = 1'b0;
  logic        p3_jump     = 1'b0;
  logic        imem_ready  = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic        imem_rerror = 1'b0;
  logic [31:0] p1_pc       = '0;
  logic [31:0] imem_rdata  = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] p2_instr;
  logic        p2_instr_valid, p2_fetch_fault, p2_pipeline_bubble;

  cpu_ifetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'hffff0000)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .stall              (stall),
    .p3_jump            (p3_jump),
    .p1_pc              (p1_pc),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .imem_rerror        (imem_rerror),
    .p2_instr           (p2_instr),
    .p2_instr_valid     (p2_instr_valid),
    .p2_fetch_fault     (p2_fetch_fault),
    .p2_pipeline_bubble (p2_pipeline_bubble)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned due;
    logic        stale;
    logic        err;
    logic [31:0] addr;
  } bus_req_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_word_t;

  bus_req_t  pend_q[$];
  exp_word_t sb_q[$];

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, lat = 1, arrived = 0;
  int unsigned n_issue = 0, n_bubble = 0, n_valid = 0, n_fault = 0;
  logic        cur_stale = 1'b0;
  logic [31:0] err_addr  = 32'hffff_fffc;
  logic        last_valid, last_bubble, last_req;
  logic [31:0] last_pop_instr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return {addr[15:0] ^ 16'hc3a5, ~addr[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, then advance bus and PC models.
  task automatic step();
    logic        iss, pop, expv;
    int unsigned used, stale_n;
    exp_word_t   e;
    @(negedge clock);
    iss         = imem_req && imem_ready;
    last_valid  = p2_instr_valid;
    last_bubble = p2_pipeline_bubble;
    last_req    = imem_req;
    check_eq("bubble", p2_pipeline_bubble, !iss);
    if (imem_req) check_eq("addr", imem_addr, p1_pc);
    expv = (arrived > 0) && !p3_jump;
    check_eq("valid", p2_instr_valid, expv);
    pop = expv && !stall;
    stale_n = (imem_rvalid && cur_stale) ? 1 : 0;
    foreach (pend_q[i]) if (pend_q[i].stale) stale_n++;
    if (p3_jump) used = stale_n;
    else used = pend_q.size() + (imem_rvalid ? 1 : 0) + arrived - (pop ? 1 : 0);
    check_eq("req_credit", imem_req, !stall && (used < DEPTH));
    if (pop && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("instr", p2_instr, e.data);
      check_eq("fault", p2_fetch_fault, e.err);
      last_pop_instr = p2_instr;
      arrived--;
    end
    if (imem_rvalid && !cur_stale && !p3_jump) arrived++;
    if (p3_jump) begin
      sb_q.delete();
      arrived = 0;
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
    end
    if (iss) begin
      pend_q.push_back('{due: cyc + lat, stale: 1'b0, err: (p1_pc == err_addr), addr: p1_pc});
      sb_q.push_back('{err: (p1_pc == err_addr), data: word_of(p1_pc)});
      n_issue++;
    end
    if (p2_pipeline_bubble) n_bubble++;
    if (p2_instr_valid) n_valid++;
    if (p2_instr_valid && p2_fetch_fault) n_fault++;
    @(posedge clock);
    #1;
    cyc++;
    p3_jump = 1'b0;
    if (iss) p1_pc = p1_pc + 32'd4;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend_q[0].addr);
      imem_rerror = pend_q[0].err;
      cur_stale   = pend_q[0].stale;
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_rerror = 1'b0;
      cur_stale   = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    logic done;
    done       = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      done = (pend_q.size() == 0) && (arrived == 0) && !imem_rvalid;
    end
    check_eq(tag, done, 1'b1);
  endtask

  // Asynchronous reset mid-cycle; responses still in flight on the bus are never delivered.
  task automatic reset_pulse();
    int unsigned late;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_valid", p2_instr_valid, 1'b0);
    check_eq("rst_instr", p2_instr, 32'h0);
    check_eq("rst_fault", p2_fetch_fault, 1'b0);
    check_eq("rst_bubble", p2_pipeline_bubble, 1'b1);
    late = pend_q.size() + (imem_rvalid ? 1 : 0);
    pend_q.delete();
    sb_q.delete();
    arrived     = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_rerror = 1'b0;
    cur_stale   = 1'b0;
    $display("note: %0d late bus responses withheld after reset (protocol violation)", late);
    @(posedge clock);
    #1;
    check_eq("rst_hold_req", imem_req, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b0, v0, f0, i0;
    logic [31:0] pc_hold;
    #1 reset_n = 1'b0;
    #2;
    check_eq("reset_req", imem_req, 1'b0);
    check_eq("reset_valid", p2_instr_valid, 1'b0);
    check_eq("reset_instr", p2_instr, 32'h0);
    check_eq("reset_fault", p2_fetch_fault, 1'b0);
    check_eq("reset_bubble", p2_pipeline_bubble, 1'b1);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // 1-cycle latency stream 0,4,8
    lat = 1;
    imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) imem_ready = 1'b0;
      step();
      check_eq("t1_valid", last_valid, (i >= 2) && (i < 5));
      if (i < 3) check_eq("t1_bubble", last_bubble, 1'b0);
    end

    // bus not ready for 3 cycles
    imem_ready = 1'b1;
    step();
    b0 = n_bubble;
    pc_hold = p1_pc;
    imem_ready = 1'b0;
    repeat (3) step();
    check_eq("t2_bubbles", n_bubble - b0, 3);
    check_eq("t2_addr_held", imem_addr, pc_hold);
    imem_ready = 1'b1;
    step();
    check_eq("t2_resume", last_bubble, 1'b0);
    drain("t2_drain");

    // full credit with 4-cycle latency and stall
    lat = 4;
    imem_ready = 1'b1;
    i0 = n_issue;
    repeat (4) step();
    check_eq("t3_issued", n_issue - i0, 4);
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("t3_req_low", last_req, 1'b0);
    end
    check_eq("t3_valid_stalled", last_valid, 1'b1);
    stall = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t3_pop_run", last_valid, 1'b1);
    end
    step();
    check_eq("t3_empty", last_valid, 1'b0);
    drain("t3_drain");

    // jump with 3 requests in flight
    lat = 5;
    imem_ready = 1'b1;
    repeat (3) step();
    p3_jump = 1'b1;
    p1_pc = 32'h100;
    v0 = n_valid;
    step();
    drain("t4_drain");
    check_eq("t4_valid_cycles", n_valid - v0, 1);
    check_eq("t4_word", last_pop_instr, word_of(32'h100));

    // jump coinciding with a response and a non-empty FIFO
    lat = 2;
    imem_ready = 1'b1;
    repeat (3) step();
    imem_ready = 1'b0;
    p3_jump = 1'b1;
    p1_pc = 32'h200;
    step();
    check_eq("t5_jump_valid", last_valid, 1'b0);
    step();
    check_eq("t5_after_valid", last_valid, 1'b0);
    check_eq("t5_req", last_req, 1'b1);
    imem_ready = 1'b1;
    step();
    drain("t5_drain");
    check_eq("t5_word", last_pop_instr, word_of(32'h200));

    // bus error on the 2nd response, then reset mid-burst
    lat = 1;
    err_addr = p1_pc + 32'd4;
    f0 = n_fault;
    imem_ready = 1'b1;
    repeat (3) step();
    drain("t6_drain");
    check_eq("t6_faults", n_fault - f0, 1);
    lat = 3;
    imem_ready = 1'b1;
    repeat (3) step();
    reset_pulse();
    lat = 1;
    imem_ready = 1'b1;
    repeat (2) step();
    drain("t6_recover_drain");

    // random traffic
    err_addr = 32'h40;
    for (int i = 0; i < 400; i++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 5) == 0);
      lat        = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        p3_jump = 1'b1;
        p1_pc   = 32'($urandom_range(0, 63)) << 2;
      end
      step();
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
